// File: rtl/instr_fetch_align_if.sv
// Instruction-memory bus between the fetch unit and the instruction memory.
// Latency: imem_rdata is valid exactly one cycle after imem_req.
// Backpressure: none; the memory always answers, the fetch unit throttles itself.
interface instr_fetch_align_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rdata);
endinterface

// File: rtl/instr_fetch_align.sv
// Fetches 32-bit words, splits them into halfword parcels and issues aligned RVC/32-bit instructions to IF_ID.
// Latency: a word returning in cycle N can be issued into IF_ID at the end of cycle N (bypass through the queue).
// Backpressure: hz holds IF_ID while the queue keeps filling; fetching stops when a returning word would not fit.
module instr_fetch_align #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       Rst,
  input  logic                       hz,
  input  logic                       dbg,
  input  logic                       mem_hold,
  input  logic                       branch,
  input  logic [31:0]                branoff,
  instr_fetch_align_if.master        imem,
  output logic [31:0]                ins,
  output logic [31:0]                IF_ID_pres_addr,
  output logic                       comp_sig,
  output logic                       if_valid
);

  typedef enum logic [1:0] {BOOT, RUN, REDIR} state_t;

  localparam logic [31:0] BOOT_ADDR = {RESET_VEC[31:2], 2'b00};
  localparam logic [31:0] BOOT_HEAD = {RESET_VEC[31:1], 1'b0};

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0][15:0]  q_q, q_d;
  logic [31:0]       head_q, head_d;
  logic              epoch_q, epoch_d;
  logic              skip_q, skip_d;
  logic [31:0]       fetch_addr_q, fetch_addr_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic              req_epoch_q, req_epoch_d;
  logic              resp_vld_q, resp_vld_d;
  logic              resp_epoch_q, resp_epoch_d;
  logic [31:0]       ins_q, ins_d;
  logic [31:0]       pc_q, pc_d;
  logic              comp_q, comp_d;
  logic              vld_q, vld_d;

  logic [5:0][15:0]  avail;
  logic [1:0]        n_in;
  logic [2:0]        n_avail;
  logic              accept;
  logic              head_comp;
  logic [2:0]        need;
  logic              have_instr;
  logic [2:0]        pop;
  logic [2:0]        idx;
  logic              unused_branoff;

  // Bit 0 of the redirect target has no meaning for halfword-aligned code.
  assign unused_branoff = branoff[0];

  // Next-state: merge queue with returning word, issue/pop the head, redirect, and throttle fetches.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    q_d          = q_q;
    head_d       = head_q;
    epoch_d      = epoch_q;
    skip_d       = skip_q;
    fetch_addr_d = fetch_addr_q;
    req_d        = 1'b0;
    addr_d       = addr_q;
    req_epoch_d  = epoch_q;
    resp_vld_d   = req_q;
    resp_epoch_d = req_epoch_q;
    ins_d        = ins_q;
    pc_d         = pc_q;
    comp_d       = comp_q;
    vld_d        = vld_q;
    pop          = 3'd0;
    idx          = 3'd0;

    // Responses tagged with an old epoch belong to a flushed path.
    accept = resp_vld_q && (resp_epoch_q == epoch_q) && (state_q != BOOT);
    n_in   = !accept ? 2'd0 : (skip_q ? 2'd1 : 2'd2);

    // Queued parcels first, then the halfwords of the returning word.
    avail = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < cnt_q) avail[k] = q_q[k];
    end
    if (accept) begin
      if (skip_q) begin
        avail[cnt_q] = imem.imem_rdata[31:16];
      end else begin
        avail[cnt_q]        = imem.imem_rdata[15:0];
        avail[cnt_q + 3'd1] = imem.imem_rdata[31:16];
      end
    end
    n_avail    = cnt_q + {1'b0, n_in};
    head_comp  = (avail[0][1:0] != 2'b11);
    need       = head_comp ? 3'd1 : 3'd2;
    have_instr = (n_avail >= need);

    if (branch) begin
      epoch_d      = ~epoch_q;
      cnt_d        = 3'd0;
      head_d       = {branoff[31:1], 1'b0};
      skip_d       = branoff[1];
      req_d        = 1'b1;
      addr_d       = {branoff[31:2], 2'b00};
      req_epoch_d  = ~epoch_q;
      fetch_addr_d = {branoff[31:2], 2'b00} + 32'd4;
      ins_d        = 32'd0;
      comp_d       = 1'b0;
      vld_d        = 1'b0;
      state_d      = REDIR;
    end else begin
      if (!hz) begin
        if (have_instr) begin
          ins_d  = head_comp ? {16'h0000, avail[0]} : {avail[1], avail[0]};
          pc_d   = head_q;
          comp_d = head_comp;
          vld_d  = 1'b1;
          pop    = need;
        end else begin
          ins_d  = 32'd0;
          comp_d = 1'b0;
          vld_d  = 1'b0;
        end
      end
      for (int k = 0; k < 4; k++) begin
        idx    = 3'(k) + pop;
        q_d[k] = avail[idx];
      end
      cnt_d  = n_avail - pop;
      head_d = head_q + {28'd0, pop, 1'b0};
      if (accept) begin
        skip_d = 1'b0;
        if (state_q == REDIR) state_d = RUN;
      end
      // A new fetch is only allowed if every word already requested plus this one still fits in 4 parcels.
      if (state_q == BOOT) begin
        req_d        = 1'b1;
        addr_d       = fetch_addr_q;
        fetch_addr_d = fetch_addr_q + 32'd4;
        state_d      = RUN;
      end else if (({1'b0, cnt_d} + {2'b00, req_q, 1'b0}) <= 4'd2) begin
        req_d        = 1'b1;
        addr_d       = fetch_addr_q;
        fetch_addr_d = fetch_addr_q + 32'd4;
      end
    end
  end

  // State update: reset wins over everything, a debug/memory freeze holds every register.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_q      <= BOOT;
      cnt_q        <= 3'd0;
      q_q          <= '0;
      head_q       <= BOOT_HEAD;
      epoch_q      <= 1'b0;
      skip_q       <= RESET_VEC[1];
      fetch_addr_q <= BOOT_ADDR;
      req_q        <= 1'b0;
      addr_q       <= BOOT_ADDR;
      req_epoch_q  <= 1'b0;
      resp_vld_q   <= 1'b0;
      resp_epoch_q <= 1'b0;
      ins_q        <= 32'd0;
      pc_q         <= RESET_VEC;
      comp_q       <= 1'b0;
      vld_q        <= 1'b0;
    end else if (!(dbg || mem_hold)) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      q_q          <= q_d;
      head_q       <= head_d;
      epoch_q      <= epoch_d;
      skip_q       <= skip_d;
      fetch_addr_q <= fetch_addr_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      req_epoch_q  <= req_epoch_d;
      resp_vld_q   <= resp_vld_d;
      resp_epoch_q <= resp_epoch_d;
      ins_q        <= ins_d;
      pc_q         <= pc_d;
      comp_q       <= comp_d;
      vld_q        <= vld_d;
    end
  end

  assign imem.imem_req   = req_q;
  assign imem.imem_addr  = addr_q;
  assign ins             = ins_q;
  assign IF_ID_pres_addr = pc_q;
  assign comp_sig        = comp_q;
  assign if_valid        = vld_q;

endmodule

// File: tb/tb_instr_fetch_align.sv
// Directed bench for instr_fetch_align with a one-cycle instruction memory model.
// Latency: memory answers one cycle after a sampled request, holding data while frozen.
// Backpressure: none; stalls and freezes are driven directly by each scenario task.
module tb_instr_fetch_align;
  logic        clk;
  logic        Rst;
  logic        hz, dbg, mem_hold, branch;
  logic [31:0] branoff;
  logic [31:0] ins, pc;
  logic        comp_sig, if_valid;
  logic [31:0] mem [0:127];
  int          total;
  int          passed;

  instr_fetch_align_if bus ();

  instr_fetch_align #(.RESET_VEC(32'h0000_0000)) dut (
    .clk(clk), .Rst(Rst), .hz(hz), .dbg(dbg), .mem_hold(mem_hold),
    .branch(branch), .branoff(branoff), .imem(bus),
    .ins(ins), .IF_ID_pres_addr(pc), .comp_sig(comp_sig), .if_valid(if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial bus.imem_rdata = 32'd0;
  always @(posedge clk) begin
    if (!(dbg || mem_hold) && bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr[8:2]];
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (if_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
    mem[0] = 32'h00A00093;
  endtask

  task automatic do_reset();
    Rst = 1'b0; hz = 1'b0; dbg = 1'b0; mem_hold = 1'b0; branch = 1'b0; branoff = 32'd0;
    step();
    step();
  endtask

  task automatic test_reset();
    load_mem();
    do_reset();
    dbg = 1'b1; branch = 1'b1; hz = 1'b1; branoff = 32'h0000_0100;
    step();
    step();
    total++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", bus.imem_req); else passed++;
    total++; if (bus.imem_addr !== 32'd0) $display("FAIL reset_addr got %h exp 0", bus.imem_addr); else passed++;
    total++; if (ins !== 32'd0) $display("FAIL reset_ins got %h exp 0", ins); else passed++;
    total++; if (pc !== 32'd0) $display("FAIL reset_pc got %h exp 0", pc); else passed++;
    total++; if (comp_sig !== 1'b0) $display("FAIL reset_comp got %b exp 0", comp_sig); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", if_valid); else passed++;
    dbg = 1'b0; branch = 1'b0; hz = 1'b0; branoff = 32'd0;
  endtask

  task automatic test_boot();
    bit ok;
    load_mem();
    do_reset();
    Rst = 1'b1;
    step();
    total++; if (bus.imem_req !== 1'b1) $display("FAIL boot_req got %b exp 1", bus.imem_req); else passed++;
    total++; if (bus.imem_addr !== 32'd0) $display("FAIL boot_addr got %h exp 0", bus.imem_addr); else passed++;
    wait_valid(2, ok);
    total++; if (!ok) $display("FAIL boot_latency got no valid exp valid by cycle 3"); else passed++;
    total++; if (ins !== 32'h00A00093) $display("FAIL boot_ins got %h exp 00a00093", ins); else passed++;
    total++; if (pc !== 32'd0) $display("FAIL boot_pc got %h exp 0", pc); else passed++;
    total++; if (comp_sig !== 1'b0) $display("FAIL boot_comp got %b exp 0", comp_sig); else passed++;
    wait_valid(4, ok);
    total++; if (ins !== 32'h00100013) $display("FAIL boot_ins2 got %h exp 00100013", ins); else passed++;
    total++; if (pc !== 32'd4) $display("FAIL boot_pc2 got %h exp 4", pc); else passed++;
  endtask

  task automatic test_mixed();
    bit ok;
    logic [31:0] e_ins [4];
    logic [31:0] e_pc [4];
    logic        e_comp [4];
    load_mem();
    mem[0] = 32'h0093_4501;
    mem[1] = 32'h4505_0513;
    mem[2] = 32'h0000_0001;
    e_ins[0] = 32'h0000_4501; e_pc[0] = 32'h0; e_comp[0] = 1'b1;
    e_ins[1] = 32'h0513_0093; e_pc[1] = 32'h2; e_comp[1] = 1'b0;
    e_ins[2] = 32'h0000_4505; e_pc[2] = 32'h6; e_comp[2] = 1'b1;
    e_ins[3] = 32'h0000_0001; e_pc[3] = 32'h8; e_comp[3] = 1'b1;
    do_reset();
    Rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_valid(6, ok);
      total++; if (!ok) $display("FAIL mixed_timeout%0d got no valid exp valid", i); else passed++;
      total++; if (ins !== e_ins[i]) $display("FAIL mixed_ins%0d got %h exp %h", i, ins, e_ins[i]); else passed++;
      total++; if (pc !== e_pc[i]) $display("FAIL mixed_pc%0d got %h exp %h", i, pc, e_pc[i]); else passed++;
      total++; if (comp_sig !== e_comp[i]) $display("FAIL mixed_comp%0d got %b exp %b", i, comp_sig, e_comp[i]); else passed++;
    end
  endtask

  task automatic test_redirect();
    bit ok;
    load_mem();
    mem[65] = 32'h4585_ABCD;
    mem[66] = 32'h0020_0193;
    do_reset();
    Rst = 1'b1;
    wait_valid(4, ok);
    for (int i = 0; i < 4; i++) begin
      if (bus.imem_req === 1'b1) break;
      step();
    end
    total++; if (bus.imem_req !== 1'b1) $display("FAIL redir_inflight got %b exp 1", bus.imem_req); else passed++;
    branch = 1'b1; branoff = 32'h0000_0106;
    step();
    branch = 1'b0;
    total++; if (bus.imem_req !== 1'b1) $display("FAIL redir_req got %b exp 1", bus.imem_req); else passed++;
    total++; if (bus.imem_addr !== 32'h104) $display("FAIL redir_addr got %h exp 104", bus.imem_addr); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL redir_bubble got %b exp 0", if_valid); else passed++;
    total++; if (ins !== 32'd0) $display("FAIL redir_bubble_ins got %h exp 0", ins); else passed++;
    wait_valid(6, ok);
    total++; if (ins !== 32'h0000_4585) $display("FAIL redir_ins got %h exp 00004585", ins); else passed++;
    total++; if (pc !== 32'h106) $display("FAIL redir_pc got %h exp 106", pc); else passed++;
    total++; if (comp_sig !== 1'b1) $display("FAIL redir_comp got %b exp 1", comp_sig); else passed++;
    wait_valid(6, ok);
    total++; if (ins !== 32'h0020_0193) $display("FAIL redir_ins2 got %h exp 00200193", ins); else passed++;
    total++; if (pc !== 32'h108) $display("FAIL redir_pc2 got %h exp 108", pc); else passed++;
  endtask

  task automatic test_double_branch();
    bit ok;
    load_mem();
    do_reset();
    Rst = 1'b1;
    wait_valid(4, ok);
    branch = 1'b1; branoff = 32'h0000_0106;
    step();
    branoff = 32'h0000_0180;
    step();
    branch = 1'b0;
    total++; if (bus.imem_addr !== 32'h180) $display("FAIL dbl_addr got %h exp 180", bus.imem_addr); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL dbl_bubble got %b exp 0", if_valid); else passed++;
    wait_valid(6, ok);
    total++; if (pc !== 32'h180) $display("FAIL dbl_pc got %h exp 180", pc); else passed++;
    total++; if (ins !== mem[96]) $display("FAIL dbl_ins got %h exp %h", ins, mem[96]); else passed++;
  endtask

  task automatic test_wrap();
    bit ok;
    load_mem();
    do_reset();
    Rst = 1'b1;
    wait_valid(4, ok);
    branch = 1'b1; branoff = 32'hFFFF_FFFC;
    step();
    branch = 1'b0;
    wait_valid(6, ok);
    total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h exp fffffffc", pc); else passed++;
    total++; if (ins !== 32'h07F0_0013) $display("FAIL wrap_ins got %h exp 07f00013", ins); else passed++;
    wait_valid(6, ok);
    total++; if (pc !== 32'd0) $display("FAIL wrap_pc2 got %h exp 0", pc); else passed++;
    total++; if (ins !== 32'h00A0_0093) $display("FAIL wrap_ins2 got %h exp 00a00093", ins); else passed++;
  endtask

  task automatic test_stall();
    bit ok;
    load_mem();
    do_reset();
    Rst = 1'b1;
    wait_valid(4, ok);
    hz = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (ins !== 32'h00A00093) $display("FAIL stall_ins%0d got %h exp 00a00093", i, ins); else passed++;
      total++; if (pc !== 32'd0) $display("FAIL stall_pc%0d got %h exp 0", i, pc); else passed++;
      if (i > 0) begin
        total++; if (bus.imem_req !== 1'b0) $display("FAIL stall_full_req%0d got %b exp 0", i, bus.imem_req); else passed++;
      end
    end
    hz = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      wait_valid(6, ok);
      total++; if (pc !== 32'(k * 4)) $display("FAIL stall_seq_pc%0d got %h exp %h", k, pc, 32'(k * 4)); else passed++;
      total++; if (ins !== mem[k]) $display("FAIL stall_seq_ins%0d got %h exp %h", k, ins, mem[k]); else passed++;
    end
  endtask

  task automatic test_freeze();
    bit ok;
    load_mem();
    do_reset();
    Rst = 1'b1;
    wait_valid(4, ok);
    wait_valid(4, ok);
    mem_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (ins !== 32'h00100013) $display("FAIL frz_ins%0d got %h exp 00100013", i, ins); else passed++;
      total++; if (pc !== 32'd4) $display("FAIL frz_pc%0d got %h exp 4", i, pc); else passed++;
      total++; if (if_valid !== 1'b1) $display("FAIL frz_valid%0d got %b exp 1", i, if_valid); else passed++;
      total++; if (bus.imem_req !== 1'b1) $display("FAIL frz_req%0d got %b exp 1", i, bus.imem_req); else passed++;
      total++; if (bus.imem_addr !== 32'hC) $display("FAIL frz_addr%0d got %h exp c", i, bus.imem_addr); else passed++;
    end
    mem_hold = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      wait_valid(6, ok);
      total++; if (pc !== 32'(k * 4)) $display("FAIL frz_seq_pc%0d got %h exp %h", k, pc, 32'(k * 4)); else passed++;
      total++; if (ins !== mem[k]) $display("FAIL frz_seq_ins%0d got %h exp %h", k, ins, mem[k]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    load_mem();
    do_reset();
    Rst = 1'b1;
    wait_valid(4, ok);
    branch = 1'b1; branoff = 32'h0000_0106;
    step();
    branch = 1'b0;
    Rst = 1'b0;
    step();
    total++; if (bus.imem_req !== 1'b0) $display("FAIL rmid_req got %b exp 0", bus.imem_req); else passed++;
    total++; if (bus.imem_addr !== 32'd0) $display("FAIL rmid_addr got %h exp 0", bus.imem_addr); else passed++;
    total++; if (ins !== 32'd0) $display("FAIL rmid_ins got %h exp 0", ins); else passed++;
    total++; if (pc !== 32'd0) $display("FAIL rmid_pc got %h exp 0", pc); else passed++;
    total++; if (comp_sig !== 1'b0) $display("FAIL rmid_comp got %b exp 0", comp_sig); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL rmid_valid got %b exp 0", if_valid); else passed++;
    Rst = 1'b1;
    step();
    total++; if (bus.imem_addr !== 32'd0) $display("FAIL rmid_refetch got %h exp 0", bus.imem_addr); else passed++;
    wait_valid(4, ok);
    total++; if (pc !== 32'd0) $display("FAIL rmid_first_pc got %h exp 0", pc); else passed++;
    total++; if (ins !== 32'h00A00093) $display("FAIL rmid_first_ins got %h exp 00a00093", ins); else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    Rst = 1'b0; hz = 1'b0; dbg = 1'b0; mem_hold = 1'b0; branch = 1'b0; branoff = 32'd0;
    test_reset();
    test_boot();
    test_mixed();
    test_redirect();
    test_double_branch();
    test_wrap();
    test_stall();
    test_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
